// File: rtl/trng_rst_pkg.sv
// Shared types and defaults for the TRNG software-reset sequencer.
package trng_rst_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 4;
  localparam int unsigned CNT_W_DEF       = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/rng_seq_cnt.sv
// Loadable saturating down-counter shared by the pulse and settle phases.
module rng_seq_cnt
  import trng_rst_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/rng_rst_seq_ctrl.sv
// TRNG software-reset sequencer: pulse the reset, wait for the synchroniser
// to settle, then signal completion while blocking datapath access.
module rng_rst_seq_ctrl
  import trng_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             sw_reset_req,
  input  logic [3:0]       cfg_pulse_len,
  input  logic [CNT_W-1:0] cfg_settle_len,
  output logic             rng_sw_reset,
  output logic             rng_busy,
  output logic             rng_access_en,
  output logic             sw_reset_done,
  output logic             req_coalesced
);

  localparam logic [CNT_W-1:0] SETTLE_MIN = CNT_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  seq_state_e       state_r;
  seq_state_e       state_nxt_s;
  logic             pending_r;
  logic             pending_nxt_s;
  logic             coal_nxt_s;
  logic [CNT_W-1:0] settle_len_r;
  logic [CNT_W-1:0] settle_floor_s;
  logic [CNT_W-1:0] pulse_load_s;
  logic [CNT_W-1:0] cnt_load_val_s;
  logic             cnt_load_s;
  logic             cnt_zero_s;

  rng_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .zero     (cnt_zero_s)
  );

  // Clamp the configured lengths to their legal minimums.
  always_comb begin
    pulse_load_s   = (cfg_pulse_len == 4'd0) ? '0 : CNT_W'(cfg_pulse_len - 4'd1);
    settle_floor_s = (cfg_settle_len < SETTLE_MIN) ? SETTLE_MIN : cfg_settle_len;
  end

  // Next-state, pending-flag and counter-load decisions.
  always_comb begin
    state_nxt_s    = state_r;
    pending_nxt_s  = pending_r;
    coal_nxt_s     = 1'b0;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = pulse_load_s;
    case (state_r)
      ST_IDLE: begin
        if (sw_reset_req) begin
          state_nxt_s = ST_ASSERT;
          cnt_load_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        pending_nxt_s = pending_r | sw_reset_req;
        coal_nxt_s    = pending_r & sw_reset_req;
        if (cnt_zero_s) begin
          state_nxt_s    = ST_SETTLE;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = settle_len_r - CNT_ONE;
        end else begin
          state_nxt_s = ST_ASSERT;
        end
      end
      ST_SETTLE: begin
        pending_nxt_s = pending_r | sw_reset_req;
        coal_nxt_s    = pending_r & sw_reset_req;
        if (cnt_zero_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_DONE: begin
        // The restart consumes the pending flag; a same-cycle strobe re-arms it
        // only when the restart was already owed to an earlier request.
        pending_nxt_s = pending_r & sw_reset_req;
        if (pending_r | sw_reset_req) begin
          state_nxt_s = ST_ASSERT;
          cnt_load_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        pending_nxt_s = 1'b0;
      end
    endcase
  end

  // State, pending flag, latched settle length and registered outputs.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_r       <= ST_IDLE;
      pending_r     <= 1'b0;
      settle_len_r  <= '0;
      rng_sw_reset  <= 1'b0;
      rng_busy      <= 1'b0;
      rng_access_en <= 1'b1;
      sw_reset_done <= 1'b0;
      req_coalesced <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
      if ((state_nxt_s == ST_ASSERT) && (state_r != ST_ASSERT)) begin
        settle_len_r <= settle_floor_s;
      end else begin
        settle_len_r <= settle_len_r;
      end
      rng_sw_reset  <= (state_nxt_s == ST_ASSERT);
      rng_busy      <= (state_nxt_s != ST_IDLE);
      rng_access_en <= (state_nxt_s == ST_IDLE);
      sw_reset_done <= (state_nxt_s == ST_DONE);
      req_coalesced <= coal_nxt_s;
    end
  end

endmodule

// File: tb/tb_rng_rst_seq_ctrl.sv
// Self-checking bench for rng_rst_seq_ctrl: directed scenarios plus random
// traffic against a timeline model of each reset sequence.
module tb_rng_rst_seq_ctrl;

  localparam int SYNC = 4;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          sw_reset_req = 1'b0;
  logic [3:0]    cfg_pulse_len = 4'd3;
  logic [CW-1:0] cfg_settle_len = 8'd10;
  logic          rng_sw_reset;
  logic          rng_busy;
  logic          rng_access_en;
  logic          sw_reset_done;
  logic          req_coalesced;
  logic [4:0]    act;

  int checks = 0;
  int errors = 0;

  // Model: a sequence is a window of cycles after the request cycle.
  int cyc = 0;
  int m_start = 0;
  int m_p = 0;
  int m_s = 0;
  int m_done = 0;
  bit m_active = 1'b0;
  bit m_pending = 1'b0;
  bit m_coal = 1'b0;

  always #5 clk = ~clk;

  assign act = {rng_sw_reset, rng_busy, rng_access_en, sw_reset_done, req_coalesced};

  rng_rst_seq_ctrl #(
    .SYNC_STAGES (SYNC),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .sys_rst        (sys_rst),
    .sw_reset_req   (sw_reset_req),
    .cfg_pulse_len  (cfg_pulse_len),
    .cfg_settle_len (cfg_settle_len),
    .rng_sw_reset   (rng_sw_reset),
    .rng_busy       (rng_busy),
    .rng_access_en  (rng_access_en),
    .sw_reset_done  (sw_reset_done),
    .req_coalesced  (req_coalesced)
  );

  task automatic start_seq();
    m_start  = cyc;
    m_p      = (cfg_pulse_len == 4'd0) ? 1 : int'(cfg_pulse_len);
    m_s      = (int'(cfg_settle_len) < SYNC + 1) ? SYNC + 1 : int'(cfg_settle_len);
    m_done   = cyc + m_p + m_s + 1;
    m_active = 1'b1;
  endtask

  function automatic logic [4:0] exp_vec();
    return {m_active && (cyc <= m_start + m_p), m_active, !m_active,
            m_active && (cyc == m_done), m_coal};
  endfunction

  // Drive one cycle of inputs, advance the model, and land #1 after the edge.
  task automatic tick(input logic req, input logic rst);
    bit coal;
    coal = 1'b0;
    sys_rst = rst;
    sw_reset_req = req;
    if (rst) begin
      m_active  = 1'b0;
      m_pending = 1'b0;
    end else if (!m_active) begin
      if (req) start_seq();
    end else if (cyc == m_done) begin
      if (m_pending || req) begin
        start_seq();
        m_pending = m_pending && req;
      end else begin
        m_active = 1'b0;
      end
    end else if (req) begin
      coal = m_pending;
      m_pending = 1'b1;
    end
    m_coal = coal;
    cyc++;
    @(posedge clk);
    #1;
    sys_rst = 1'b0;
    sw_reset_req = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      checks++;
      if (act !== 5'b00100) begin
        errors++;
        $display("FAIL reset cyc=%0d act=%b exp=%b", i, act, 5'b00100);
      end
    end
  endtask

  task automatic test_basic();
    logic [4:0] sv;
    cfg_pulse_len = 4'd3;
    cfg_settle_len = 8'd10;
    for (int k = 1; k <= 16; k++) begin
      tick(k == 1, 1'b0);
      sv = {k <= 3, k <= 14, k > 14, k == 14, 1'b0};
      checks++;
      if (act !== sv) begin
        errors++;
        $display("FAIL basic k=%0d act=%b exp=%b", k, act, sv);
      end
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL basic_model k=%0d act=%b exp=%b", k, act, exp_vec());
      end
    end
  endtask

  task automatic test_min_len();
    logic [4:0] sv;
    cfg_pulse_len = 4'd0;
    cfg_settle_len = 8'd2;
    for (int k = 1; k <= 9; k++) begin
      tick(k == 1, 1'b0);
      sv = {k == 1, k <= 7, k > 7, k == 7, 1'b0};
      checks++;
      if (act !== sv) begin
        errors++;
        $display("FAIL min_len k=%0d act=%b exp=%b", k, act, sv);
      end
    end
  endtask

  task automatic test_coalesce();
    logic [4:0] sv;
    cfg_pulse_len = 4'd2;
    cfg_settle_len = 8'd6;
    for (int k = 1; k <= 20; k++) begin
      tick((k - 1 == 0) || (k - 1 == 5) || (k - 1 == 7), 1'b0);
      sv = {(k <= 2) || (k >= 10 && k <= 11), k <= 18, k > 18,
            (k == 9) || (k == 18), k == 8};
      checks++;
      if (act !== sv) begin
        errors++;
        $display("FAIL coalesce k=%0d act=%b exp=%b", k, act, sv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] sv;
    cfg_pulse_len = 4'd1;
    cfg_settle_len = 8'd5;
    for (int k = 1; k <= 16; k++) begin
      tick((k - 1 == 0) || (k - 1 == 7), 1'b0);
      sv = {(k == 1) || (k == 8), k <= 14, k > 14, (k == 7) || (k == 14), 1'b0};
      checks++;
      if (act !== sv) begin
        errors++;
        $display("FAIL back_to_back k=%0d act=%b exp=%b", k, act, sv);
      end
    end
  endtask

  task automatic test_abort();
    logic [4:0] sv;
    cfg_pulse_len = 4'd3;
    cfg_settle_len = 8'd10;
    for (int k = 1; k <= 21; k++) begin
      tick((k - 1 == 0) || (k - 1 == 1) || (k - 1 == 6), k - 1 == 2);
      sv = {(k <= 2) || (k >= 7 && k <= 9), (k <= 2) || (k >= 7 && k <= 20),
            !((k <= 2) || (k >= 7 && k <= 20)), k == 20, 1'b0};
      checks++;
      if (act !== sv) begin
        errors++;
        $display("FAIL abort k=%0d act=%b exp=%b", k, act, sv);
      end
    end
  endtask

  task automatic test_cfg_change();
    logic [4:0] sv;
    cfg_pulse_len = 4'd3;
    cfg_settle_len = 8'd6;
    for (int k = 1; k <= 28; k++) begin
      if (k == 2) cfg_pulse_len = 4'd9;
      tick((k - 1 == 0) || (k - 1 == 11), 1'b0);
      sv = {(k <= 3) || (k >= 12 && k <= 20), (k <= 10) || (k >= 12 && k <= 27),
            !((k <= 10) || (k >= 12 && k <= 27)), (k == 10) || (k == 27), 1'b0};
      checks++;
      if (act !== sv) begin
        errors++;
        $display("FAIL cfg_change k=%0d act=%b exp=%b", k, act, sv);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        cfg_pulse_len = 4'($urandom_range(0, 15));
        cfg_settle_len = 8'($urandom_range(0, 20));
      end
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_len();
    test_coalesce();
    test_back_to_back();
    test_abort();
    test_cfg_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
